// File: rtl/cfb_pkg.sv
// cfb_pkg: shared configuration and state types for the ciphertext frame buffer.
//   DEF_REGISTER_SIZE  word width of the incoming spi_pe stream
//   DEF_BITS_IN_NUM    ciphertext width in bits
//   DEF_NUM_BLOCKS     words per ciphertext frame
//   DEF_TIMEOUT_CYCLES idle cycles before a partial frame is abandoned
//                      (only meaningful when FRAME_TIMEOUT_EN is defined)
package cfb_pkg;

    localparam int DEF_REGISTER_SIZE  = 32;
    localparam int DEF_BITS_IN_NUM    = 4096;
    localparam int DEF_NUM_BLOCKS     = DEF_BITS_IN_NUM / DEF_REGISTER_SIZE;
    localparam int DEF_TIMEOUT_CYCLES = 1_000_000;

    typedef enum logic [1:0] {
        SLOT_FREE,
        SLOT_FILLING,
        SLOT_FULL,
        SLOT_READING
    } slot_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_FILL,
        W_DISCARD
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_FETCH,
        R_PRESENT
    } rd_state_t;

endpackage

// File: rtl/cfb_slot_ram.sv
// cfb_slot_ram: simple dual-port RAM holding both ping-pong frame slots.
// Address is {slot, word index}. Registered read with one cycle of latency,
// written in the plain form that synthesis maps onto block RAM.
//   clk         clock
//   write_en    write strobe
//   write_addr  write address
//   write_data  write data
//   read_en     read strobe; read_data updates on the next edge
//   read_addr   read address
//   read_data   registered read data
module cfb_slot_ram
    import cfb_pkg::*;
#(
    parameter int WIDTH  = DEF_REGISTER_SIZE,
    parameter int ADDR_W = $clog2(2 * DEF_NUM_BLOCKS)
) (
    input  logic              clk,
    input  logic              write_en,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [WIDTH-1:0]  write_data,
    input  logic              read_en,
    input  logic [ADDR_W-1:0] read_addr,
    output logic [WIDTH-1:0]  read_data
);

    logic [WIDTH-1:0] mem [2**ADDR_W];

    // NOTE: the storage array has no reset; clearing it would stop block RAM
    // inference, and slot states already mark which contents are meaningful.
    always_ff @(posedge clk) begin
        if (write_en) begin
            mem[write_addr] <= write_data;
        end
        if (read_en) begin
            read_data <= mem[read_addr];
        end
    end

endmodule

// File: rtl/ciphertext_frame_buffer.sv
// ciphertext_frame_buffer: groups the spi_pe 32-bit word stream into
// ciphertext frames (least-significant word first), holds them in a two-slot
// ping-pong buffer and streams whole frames downstream with valid/consumed.
// spi_pe cannot be stalled, so a frame arriving with no free slot is dropped.
// Optional feature: define FRAME_TIMEOUT_EN to abandon a partial frame after
// TIMEOUT_CYCLES idle cycles.
//   clk_in               clock
//   rst_in               synchronous active-high reset
//   data_in / valid_in   incoming word and its one-cycle strobe
//   consumed_in          downstream took data_out this cycle
//   data_out / valid_out current outgoing word, held until consumed
//   frame_start_out      valid_out on word index 0
//   frame_last_out       valid_out on the last word index
//   frames_received_out  frames fully captured (wraps)
//   frames_dropped_out   frames discarded (saturates)
//   overflow_out         sticky, set on the first frame dropped for lack of a slot
module ciphertext_frame_buffer
    import cfb_pkg::*;
#(
    parameter int REGISTER_SIZE = DEF_REGISTER_SIZE,
    parameter int BITS_IN_NUM   = DEF_BITS_IN_NUM
`ifdef FRAME_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic [REGISTER_SIZE-1:0] data_in,
    input  logic                     valid_in,
    input  logic                     consumed_in,
    output logic [REGISTER_SIZE-1:0] data_out,
    output logic                     valid_out,
    output logic                     frame_start_out,
    output logic                     frame_last_out,
    output logic [15:0]              frames_received_out,
    output logic [15:0]              frames_dropped_out,
    output logic                     overflow_out
);

    localparam int NUM_BLOCKS = BITS_IN_NUM / REGISTER_SIZE;
    localparam int IDX_W      = $clog2(NUM_BLOCKS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BLOCKS - 1);

    slot_state_t            slot_state [2];
    wr_state_t              wr_state, wr_next;
    rd_state_t              rd_state, rd_next;
    logic                   wr_slot, rd_slot;
    logic [IDX_W-1:0]       wr_idx, rd_idx;
    logic                   wr_last, rd_last;
    logic                   release_slot, admit, timeout, ram_we;
    logic [REGISTER_SIZE-1:0] ram_q;

    assign wr_last      = (wr_idx == LAST_IDX);
    assign rd_last      = (rd_idx == LAST_IDX);
    assign release_slot = (rd_state == R_PRESENT) && consumed_in && rd_last;
    // A slot freed on this very edge can take the new frame's first word.
    assign admit        = (slot_state[wr_slot] == SLOT_FREE) ||
                          (release_slot && (rd_slot == wr_slot));
    assign ram_we       = valid_in &&
                          ((wr_state == W_FILL) || ((wr_state == W_IDLE) && admit));

`ifdef FRAME_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [IDLE_W-1:0] idle_cnt;

    assign timeout = (wr_state != W_IDLE) && !valid_in &&
                     (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_in) begin
        if (rst_in || valid_in || (wr_state == W_IDLE) || timeout) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // ---------------- write FSM ----------------
    // NOTE: state and datapath registers use non-blocking assignments so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_in) begin
        if (rst_in) wr_state <= W_IDLE;
        else        wr_state <= wr_next;
    end

    // NOTE: the next state is defaulted first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        wr_next = wr_state;
        case (wr_state)
            W_IDLE:            if (valid_in) wr_next = admit ? W_FILL : W_DISCARD;
            W_FILL, W_DISCARD: if (timeout || (valid_in && wr_last)) wr_next = W_IDLE;
            default:           wr_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_slot             <= 1'b0;
            wr_idx              <= '0;
            frames_received_out <= '0;
            frames_dropped_out  <= '0;
            overflow_out        <= 1'b0;
        end else begin
            case (wr_state)
                W_IDLE: begin
                    if (valid_in) begin
                        wr_idx <= IDX_W'(1);
                        if (!admit) begin
                            overflow_out <= 1'b1;
                            if (frames_dropped_out != 16'hFFFF)
                                frames_dropped_out <= frames_dropped_out + 16'd1;
                        end
                    end
                end
                W_FILL, W_DISCARD: begin
                    if (timeout) begin
                        wr_idx <= '0;
                        // A discarded frame was already counted when it was refused.
                        if ((wr_state == W_FILL) && (frames_dropped_out != 16'hFFFF))
                            frames_dropped_out <= frames_dropped_out + 16'd1;
                    end else if (valid_in) begin
                        wr_idx <= wr_last ? '0 : wr_idx + IDX_W'(1);
                        if (wr_last && (wr_state == W_FILL)) begin
                            wr_slot             <= ~wr_slot;
                            frames_received_out <= frames_received_out + 16'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Slot ownership. Write-side updates come last so an admit on the same
    // slot as a release leaves it FILLING.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            slot_state[0] <= SLOT_FREE;
            slot_state[1] <= SLOT_FREE;
        end else begin
            if ((rd_state == R_IDLE) && (slot_state[rd_slot] == SLOT_FULL))
                slot_state[rd_slot] <= SLOT_READING;
            if (release_slot)
                slot_state[rd_slot] <= SLOT_FREE;
            if ((wr_state == W_IDLE) && valid_in && admit)
                slot_state[wr_slot] <= SLOT_FILLING;
            if ((wr_state == W_FILL) && valid_in && wr_last)
                slot_state[wr_slot] <= SLOT_FULL;
            if ((wr_state == W_FILL) && timeout)
                slot_state[wr_slot] <= SLOT_FREE;
        end
    end

    // ---------------- read FSM ----------------
    always_ff @(posedge clk_in) begin
        if (rst_in) rd_state <= R_IDLE;
        else        rd_state <= rd_next;
    end

    always_comb begin
        rd_next = rd_state;
        case (rd_state)
            R_IDLE:    if (slot_state[rd_slot] == SLOT_FULL) rd_next = R_FETCH;
            R_FETCH:   rd_next = R_PRESENT;
            R_PRESENT: if (consumed_in) rd_next = rd_last ? R_IDLE : R_FETCH;
            default:   rd_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rd_slot <= 1'b0;
            rd_idx  <= '0;
        end else if ((rd_state == R_PRESENT) && consumed_in) begin
            rd_idx <= rd_last ? '0 : rd_idx + IDX_W'(1);
            if (rd_last) rd_slot <= ~rd_slot;
        end
    end

    // Outputs; data_out is gated so it reads zero whenever nothing is presented.
    always_comb begin
        valid_out       = (rd_state == R_PRESENT);
        data_out        = valid_out ? ram_q : '0;
        frame_start_out = valid_out && (rd_idx == '0);
        frame_last_out  = valid_out && rd_last;
    end

    cfb_slot_ram #(
        .WIDTH  (REGISTER_SIZE),
        .ADDR_W (IDX_W + 1)
    ) u_ram (
        .clk        (clk_in),
        .write_en   (ram_we),
        .write_addr ({wr_slot, wr_idx}),
        .write_data (data_in),
        .read_en    (rd_state == R_FETCH),
        .read_addr  ({rd_slot, rd_idx}),
        .read_data  (ram_q)
    );

endmodule

// File: tb/tb_ciphertext_frame_buffer.sv
// Directed testbench for ciphertext_frame_buffer. With FRAME_TIMEOUT_EN defined
// the DUT is built with TIMEOUT_CYCLES=100 and the timeout scenario is added.
module tb_ciphertext_frame_buffer;

    localparam int W  = 32;
    localparam int NB = 128;

    logic          clk_in      = 1'b0;
    logic          rst_in      = 1'b1;
    logic [W-1:0]  data_in     = '0;
    logic          valid_in    = 1'b0;
    logic          consumed_in = 1'b0;
    logic [W-1:0]  data_out;
    logic          valid_out, frame_start_out, frame_last_out, overflow_out;
    logic [15:0]   frames_received_out, frames_dropped_out;

    ciphertext_frame_buffer #(
        .REGISTER_SIZE (W),
        .BITS_IN_NUM   (W * NB)
`ifdef FRAME_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (100)
`endif
    ) dut (
        .clk_in              (clk_in),
        .rst_in              (rst_in),
        .data_in             (data_in),
        .valid_in            (valid_in),
        .consumed_in         (consumed_in),
        .data_out            (data_out),
        .valid_out           (valid_out),
        .frame_start_out     (frame_start_out),
        .frame_last_out      (frame_last_out),
        .frames_received_out (frames_received_out),
        .frames_dropped_out  (frames_dropped_out),
        .overflow_out        (overflow_out)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc++;

    typedef struct {
        logic [W-1:0] data;
        logic         start;
        logic         last;
        int           cyc;
    } beat_t;

    beat_t        got_q [$];
    logic [W-1:0] exp_q [$];
    int           n_checks   = 0;
    int           n_fail     = 0;
    int           stable_err = 0;
    logic         prev_valid = 1'b0;
    logic         prev_cons  = 1'b0;
    logic [W-1:0] prev_data  = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Capture every handshaken word; also watch that an unconsumed word holds.
    always @(negedge clk_in) begin
        if (valid_out && prev_valid && !prev_cons && (data_out != prev_data))
            stable_err++;
        if (valid_out && consumed_in)
            got_q.push_back('{data: data_out, start: frame_start_out,
                              last: frame_last_out, cyc: cyc});
        prev_valid = valid_out;
        prev_cons  = consumed_in;
        prev_data  = data_out;
    end

    task automatic apply_reset();
        rst_in      = 1'b1;
        valid_in    = 1'b0;
        consumed_in = 1'b0;
        data_in     = '0;
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        got_q.delete();
        exp_q.delete();
    endtask

    // Drives n words base+i, one per cycle; cap is the cycle that captured the last.
    task automatic send_frame(input logic [W-1:0] base, input int n, output int cap);
        for (int i = 0; i < n; i++) begin
            data_in  = base + W'(i);
            valid_in = 1'b1;
            @(posedge clk_in);
            #1;
        end
        cap      = cyc;
        valid_in = 1'b0;
        data_in  = '0;
    endtask

    task automatic expect_frame(input logic [W-1:0] base);
        for (int i = 0; i < NB; i++) exp_q.push_back(base + W'(i));
    endtask

    task automatic wait_beats(input int n, input int budget);
        int c = 0;
        while ((got_q.size() < n) && (c < budget)) begin
            @(posedge clk_in);
            c++;
        end
        repeat (20) @(posedge clk_in);
        #1;
    endtask

    task automatic compare_stream(input string tag);
        int n;
        check({tag, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_word%0d", tag, i), got_q[i].data, exp_q[i]);
            check($sformatf("%s_flags%0d", tag, i),
                  {30'd0, got_q[i].start, got_q[i].last},
                  {30'd0, (i % NB) == 0, (i % NB) == NB - 1});
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int  cap;
        int  lat;
        logic found;

        // Reset state
        apply_reset();
        check("reset_valid", valid_out, 0);
        check("reset_data", data_out, 0);
        check("reset_flags", {frame_start_out, frame_last_out}, 0);
        check("reset_rx", frames_received_out, 0);
        check("reset_drop", frames_dropped_out, 0);
        check("reset_ovf", overflow_out, 0);

        // 1: single frame, consumer always ready
        consumed_in = 1'b1;
        send_frame(32'd1, NB, cap);
        wait_beats(NB, 1000);
        lat = (got_q.size() > 0) ? (got_q[0].cyc - cap) : -1;
        check("t1_latency", lat, 2);
        expect_frame(32'd1);
        compare_stream("t1");
        check("t1_rx", frames_received_out, 1);
        check("t1_drop", frames_dropped_out, 0);
        check("t1_ovf", overflow_out, 0);

        // 2: three frames with consumer stalled; third must be dropped
        apply_reset();
        send_frame(32'h1000, NB, cap);
        send_frame(32'h2000, NB, cap);
        send_frame(32'h3000, NB, cap);
        check("t2_rx", frames_received_out, 2);
        check("t2_drop", frames_dropped_out, 1);
        check("t2_ovf", overflow_out, 1);
        consumed_in = 1'b1;
        wait_beats(2 * NB, 2000);
        expect_frame(32'h1000);
        expect_frame(32'h2000);
        compare_stream("t2");

        // 3: third frame's first word lands on the edge releasing slot 0
        apply_reset();
        send_frame(32'h1000, NB, cap);
        send_frame(32'h2000, NB, cap);
        consumed_in = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 1000 && !found; c++) begin
            @(negedge clk_in);
            if (valid_out && frame_last_out) found = 1'b1;
        end
        check("t3_sync", found, 1);
        send_frame(32'h3000, NB, cap);
        wait_beats(3 * NB, 2000);
        expect_frame(32'h1000);
        expect_frame(32'h2000);
        expect_frame(32'h3000);
        compare_stream("t3");
        check("t3_drop", frames_dropped_out, 0);
        check("t3_ovf", overflow_out, 0);
        check("t3_rx", frames_received_out, 3);

        // 4: consumer pulses every 5th cycle
        apply_reset();
        send_frame(32'h4000, NB, cap);
        for (int c = 0; c < 3000 && got_q.size() < NB; c++) begin
            consumed_in = ((c % 5) == 4);
            @(posedge clk_in);
            #1;
        end
        consumed_in = 1'b0;
        repeat (20) @(posedge clk_in);
        #1;
        expect_frame(32'h4000);
        compare_stream("t4");
        check("t4_stable", stable_err, 0);

        // 5: reset in the middle of a frame
        apply_reset();
        consumed_in = 1'b1;
        send_frame(32'h5000, 60, cap);
        apply_reset();
        check("t5_rx", frames_received_out, 0);
        check("t5_drop", frames_dropped_out, 0);
        check("t5_valid", valid_out, 0);
        consumed_in = 1'b1;
        send_frame(32'h6000, NB, cap);
        wait_beats(NB, 1000);
        expect_frame(32'h6000);
        compare_stream("t5");
        check("t5_rx_after", frames_received_out, 1);

`ifdef FRAME_TIMEOUT_EN
        // 6: partial frame abandoned after 100 idle cycles
        apply_reset();
        consumed_in = 1'b1;
        send_frame(32'h7000, 50, cap);
        repeat (101) @(posedge clk_in);
        #1;
        send_frame(32'h8000, NB, cap);
        wait_beats(NB, 1000);
        expect_frame(32'h8000);
        compare_stream("t6");
        check("t6_drop", frames_dropped_out, 1);
        check("t6_rx", frames_received_out, 1);
`endif

        check("all_stable", stable_err, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ciphertext_frame_buffer.md
Name: ciphertext_frame_buffer

Overview:
Decryptor-side receive stage, fed directly by spi_pe's 32-bit word stream (data_out/data_valid_out). It groups words into ciphertext frames of BITS_IN_NUM bits, least-significant block first, and holds them in a two-slot ping-pong buffer. It then streams complete frames to the downstream tally multiplier using a valid/consumed handshake. spi_pe cannot be back-pressured, so a frame that arrives with no free slot is dropped whole and flagged.

Parameters:
REGISTER_SIZE, 32, word width in bits.
BITS_IN_NUM, 4096, ciphertext width in bits; NUM_BLOCKS = BITS_IN_NUM/REGISTER_SIZE = 128.
TIMEOUT_CYCLES, 1_000_000, idle cycles after which a partial frame is discarded (used only with the optional feature).

Ports:
clk_in  input  1  system clock (100 MHz)
rst_in  input  1  reset; synchronous and active-high
data_in  input  REGISTER_SIZE  received word
valid_in  input  1  one-cycle strobe; data_in is valid this cycle
consumed_in  input  1  downstream has taken data_out this cycle
data_out  output  REGISTER_SIZE  current word of the frame being streamed
valid_out  output  1  data_out is valid
frame_start_out  output  1  high with valid_out on word index 0
frame_last_out  output  1  high with valid_out on word index NUM_BLOCKS-1
frames_received_out  output  16  frames fully captured; wraps at 2^16
frames_dropped_out  output  16  frames discarded; saturates at 0xFFFF
overflow_out  output  1  sticky; set on the first dropped frame

Behaviour:
- Reset: all outputs 0. Both slots FREE. wr_slot=rd_slot=0, wr_idx=rd_idx=0. Write FSM in W_IDLE, read FSM in R_IDLE. Reset mid-frame discards all stored and partial data.
- Each slot is FREE, FILLING, FULL or READING.
- Write FSM states: W_IDLE, W_FILL, W_DISCARD.
  - W_IDLE + valid_in: admit the frame if slot wr_slot is FREE, or is released on this same edge (release has priority, so the word is accepted).
    - If admitted: write the word to index 0 and go to W_FILL.
    - If not admitted: go to W_DISCARD, set overflow_out, and increment frames_dropped_out.
  - W_FILL: each valid_in writes at wr_idx and increments it. On the word at index NUM_BLOCKS-1:
    - the slot becomes FULL;
    - wr_slot toggles;
    - frames_received_out increments;
    - return to W_IDLE.
  - W_DISCARD: count NUM_BLOCKS words in total, then return to W_IDLE. Frame alignment is preserved.
- Read FSM states: R_IDLE, R_FETCH, R_PRESENT.
  - R_IDLE: if slot rd_slot is FULL, mark it READING and go to R_FETCH.
  - R_FETCH: issue the RAM read; the next state is always R_PRESENT.
  - R_PRESENT: valid_out=1 and data_out is held stable until consumed_in.
    - On consumed_in: if rd_idx < NUM_BLOCKS-1, increment rd_idx and go to R_FETCH.
    - Otherwise: release the slot to FREE, toggle rd_slot, clear rd_idx, go to R_IDLE.
  - consumed_in outside R_PRESENT is ignored.
- Latency:
  - valid_out rises on the 2nd rising edge after the edge that captured a frame's last word.
  - Sustained throughput is 1 word per 2 cycles.
  - The write side accepts 1 word per cycle.
- Word order out matches word order in. Frames leave in arrival order.

Optional Feature:
Macro FRAME_TIMEOUT_EN.
- Defined:
  - An idle counter runs while in W_FILL or W_DISCARD and clears on every valid_in.
  - On reaching TIMEOUT_CYCLES, the partial frame is abandoned: a FILLING slot returns to FREE, wr_idx clears, and the FSM goes to W_IDLE.
  - frames_dropped_out increments for an abandoned W_FILL frame but not for an abandoned W_DISCARD frame, which was already counted.
- Undefined: no counter exists, and a partial frame waits indefinitely.

Decomposition:
- Package cfb_pkg:
  - REGISTER_SIZE and BITS_IN_NUM defaults, NUM_BLOCKS;
  - enums slot_state_t, wr_state_t, rd_state_t.
- Sub-module cfb_slot_ram:
  - simple dual-port RAM, depth 2*NUM_BLOCKS, width REGISTER_SIZE;
  - address is {slot, idx}; registered read, 1-cycle latency; BRAM-inferable.

Test Plan:
1. One frame: words 1..128 at 1 word per cycle, consumed_in held high. Expect:
   - 128 outputs with values 1..128 in order;
   - frame_start_out on value 1 and frame_last_out on value 128;
   - frames_received_out=1, overflow_out=0;
   - first valid_out 2 cycles after word 128 is captured.
2. Three frames back-to-back (values 0x1000+i, 0x2000+i, 0x3000+i), consumed_in held 0. Expect:
   - frames_received_out=2, frames_dropped_out=1, overflow_out=1;
   - after consumed_in is raised, exactly frames 0x1000 then 0x2000 are streamed;
   - no 0x3000 word ever appears.
3. Simultaneous release: time the first word of frame 3 to arrive on the same edge as the consume of frame 1's last word. Expect frame 3 accepted and streamed, frames_dropped_out=0.
4. Stalled consumer: consumed_in pulsed every 5th cycle. Expect data_out stable while valid_out is high and unconsumed; all 128 words delivered once each.
5. Reset mid-frame: assert rst_in after 60 words, then send a full new frame. Expect all counters at 0 after reset and only the new frame streamed.
6. FRAME_TIMEOUT_EN, TIMEOUT_CYCLES=100: send 50 words, idle 101 cycles, then send a full frame. Expect frames_dropped_out=1 and only the full frame streamed.
